// File: rtl/aes_seq_pkg.sv
// Shared types and widths for the sequenced AES core wrapper.
// State encodings are plain constants so legacy code can compare them.
package aes_seq_pkg;

  localparam int KEY_W = 256;
  localparam int BLK_W = 128;
  localparam int CNT_W = 32;

  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_KEY_GO   = 3'd1;
  localparam state_t S_KEY_WAIT = 3'd2;
  localparam state_t S_BLK_GO   = 3'd3;
  localparam state_t S_BLK_WAIT = 3'd4;

endpackage

// File: rtl/aes_seq_outreg.sv
// Result holding register: one entry, loads from the core and drains
// to the consumer independently of the sequencing FSM.
module aes_seq_outreg
  import aes_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cap_req_i,
  input  logic [BLK_W-1:0] cap_data_i,
  input  logic             out_ready_i,
  output logic             cap_ok_o,
  output logic             out_fire_o,
  output logic             out_valid_o,
  output logic [BLK_W-1:0] out_block_o
);

  logic             valid_q;
  logic [BLK_W-1:0] data_q;
  logic             load;

  assign cap_ok_o    = ~valid_q | out_ready_i;
  assign out_fire_o  = valid_q & out_ready_i;
  assign load        = cap_req_i & cap_ok_o;
  assign out_valid_o = valid_q;
  assign out_block_o = data_q;

  // Capture beats drain: a same-cycle capture keeps valid set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= cap_data_i;
    end else if (out_fire_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_core_seq.sv
// Sequencer wrapping a command-pulse AES core: key expansion,
// block handshakes and a decoupled result register.
module aes_core_seq
  import aes_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             keylen_in,
  input  logic             encdec_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic             key_valid,
  output logic             busy,
  output logic [CNT_W-1:0] block_count,
  output logic             core_init,
  output logic             core_next,
  output logic             core_encdec,
  output logic             core_keylen,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_block,
  input  logic             core_ready,
  input  logic             core_result_valid,
  input  logic [BLK_W-1:0] core_result
);

  state_t           state_q, state_d;
  logic             key_valid_q, key_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q;
  logic             keylen_q;
  logic             encdec_q;
  logic [BLK_W-1:0] blk_q;

  logic is_idle;
  logic key_acc;
  logic in_fire;
  logic cap_req;
  logic cap_ok;
  logic out_fire;

  assign is_idle  = (state_q == S_IDLE);
  assign key_acc  = is_idle & key_load;
  assign in_ready = is_idle & key_valid_q & ~key_load;
  assign in_fire  = in_valid & in_ready;
  assign cap_req  = (state_q == S_BLK_WAIT) & core_ready
                  & core_result_valid;

  assign busy        = ~is_idle;
  assign core_init   = (state_q == S_KEY_GO);
  assign core_next   = (state_q == S_BLK_GO);
  assign key_valid   = key_valid_q;
  assign block_count = cnt_q;
  assign core_key    = key_q;
  assign core_keylen = keylen_q;
  assign core_encdec = encdec_q;
  assign core_block  = blk_q;

  // Next-state, key-valid and transfer-count logic.
  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (key_acc)      state_d = S_KEY_GO;
        else if (in_fire) state_d = S_BLK_GO;
      end
      S_KEY_GO:   state_d = S_KEY_WAIT;
      S_KEY_WAIT: if (core_ready) state_d = S_IDLE;
      S_BLK_GO:   state_d = S_BLK_WAIT;
      S_BLK_WAIT: if (cap_req & cap_ok) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (key_acc)
      key_valid_d = 1'b0;
    else if ((state_q == S_KEY_WAIT) & core_ready)
      key_valid_d = 1'b1;
    if (key_acc)       cnt_d = '0;
    else if (out_fire) cnt_d = cnt_q + 32'd1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Core operands: held stable while the core works on them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q    <= '0;
      keylen_q <= 1'b0;
      encdec_q <= 1'b0;
      blk_q    <= '0;
    end else begin
      if (key_acc) begin
        key_q    <= key_in;
        keylen_q <= keylen_in;
        encdec_q <= encdec_in;
      end
      if (in_fire) blk_q <= in_block;
    end
  end

  aes_seq_outreg u_outreg (
    .clk        (clk),
    .reset_n    (reset_n),
    .cap_req_i  (cap_req),
    .cap_data_i (core_result),
    .out_ready_i(out_ready),
    .cap_ok_o   (cap_ok),
    .out_fire_o (out_fire),
    .out_valid_o(out_valid),
    .out_block_o(out_block)
  );

endmodule

// File: doc/aes_core_seq.md
AES_CORE_SEQ -- requirements
Module: aes_core_seq

Interface
REQ-001 clk  in  1  clock; all state on rising edge.
REQ-002 reset_n  in  1  reset, asynchronous, active-low.
REQ-003 key_load  in  1  one-cycle request: latch key_in, keylen_in and encdec_in, then run core key expansion.
REQ-004 key_in  in  256  key; 128-bit keys use bits [127:0].
REQ-005 keylen_in  in  1  0 = AES-128, 1 = AES-256.
REQ-006 encdec_in  in  1  1 = encrypt, 0 = decrypt; applies to all blocks until the next key_load.
REQ-007 in_valid / in_ready  in / out  1 / 1  input block handshake; transfer when both are 1.
REQ-008 in_block  in  128  plaintext or ciphertext block.
REQ-009 out_valid / out_ready  out / in  1 / 1  result handshake; transfer when both are 1.
REQ-010 out_block  out  128  result block.
REQ-011 key_valid  out  1  expanded key present in core.
REQ-012 busy  out  1  FSM not in S_IDLE.
REQ-013 block_count  out  32  completed output transfers since last key_load.
REQ-014 core_init, core_next  out  1 each  core command pulses.
REQ-015 core_encdec, core_keylen  out  1 each  registered mode to core.
REQ-016 core_key  out  256  registered key to core.
REQ-017 core_block  out  128  registered block to core.
REQ-018 core_ready, core_result_valid  in  1 each  core status.
REQ-019 core_result  in  128  core result; combinational, valid only while core_ready and core_result_valid are both 1.

Function
REQ-020 FSM states:
- S_IDLE
- S_KEY_GO: core_init=1 for exactly 1 cycle
- S_KEY_WAIT
- S_BLK_GO: core_next=1 for exactly 1 cycle
- S_BLK_WAIT
REQ-021 core_key, core_keylen, core_encdec and core_block are registers; they stay stable from the command pulse until the core's ready returns.
REQ-022 In S_IDLE, key_load has priority over in_valid. key_load latches key/mode, clears key_valid, clears block_count, and moves to S_KEY_GO. key_load in any other state is ignored.
REQ-023 S_KEY_GO -> S_KEY_WAIT unconditionally. S_KEY_WAIT -> S_IDLE on the first cycle with core_ready=1, setting key_valid=1.
REQ-024 in_ready = (state==S_IDLE) & key_valid & !key_load.
REQ-025 On an input transfer, in_block is latched into core_block and the FSM moves to S_BLK_GO, then S_BLK_WAIT.
REQ-026 In S_BLK_WAIT, the result is captured when core_ready & core_result_valid & (!out_valid | out_ready). Capture loads out_block, sets out_valid and returns to S_IDLE.
REQ-027 If the output register is full and not draining, the FSM holds in S_BLK_WAIT. No result is lost or overwritten.
REQ-028 The output register drains independently of the FSM. The next block may be processed while the previous result waits.
REQ-029 out_valid clears on an output transfer unless a capture happens in the same cycle, in which case it stays 1 with the new data.
REQ-030 block_count increments by 1 per output transfer and wraps from 0xFFFFFFFF to 0.
REQ-031 A key_load accepted while out_valid=1 leaves the pending result intact.
REQ-032 Latency: with out_ready held at 1, the output transfer occurs core latency + 3 cycles after the input transfer.
REQ-033 core_init and core_next are never 1 in the same cycle and are never asserted outside S_KEY_GO / S_BLK_GO.

Reset
REQ-034 Reset forces:
- state = S_IDLE
- key_valid, out_valid, in_ready, core_init, core_next, busy = 0
- block_count = 0
- all data registers = 0
REQ-035 Reset mid-operation abandons the in-flight key or block. After reset, a new key_load is required before any input is accepted.

Structure
REQ-036 Shared package aes_seq_pkg holds:
- state enum
- widths: KEY_W=256, BLK_W=128, CNT_W=32
- keylen encodings
REQ-037 One sub-module, aes_seq_outreg, holds the output register, out_valid and the capture/drain arbitration.

Verification
REQ-038 AES-128 encrypt: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a; block_count=1.
REQ-039 AES-256 decrypt: key 000102...1f, block 8ea2b7ca516745bfeafc49904b496089 -> out_block 00112233445566778899aabbccddeeff.
REQ-040 Backpressure: out_ready=0 while 2 blocks are sent -> first result held, FSM stalls in S_BLK_WAIT, in_ready=0; releasing out_ready delivers both results in order.
REQ-041 Key switch: key_load and in_valid asserted in the same cycle in S_IDLE -> key wins, in_ready=0, block_count=0, next block uses the new key.
REQ-042 in_valid before any key_load -> in_ready stays 0 and core_next is never asserted.
REQ-043 Reset asserted during S_BLK_WAIT -> all outputs reach reset values; key_valid=0 after reset is released.
